// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising PRBS checker for the LFSR generator stream
// Locks onto a received LFSR sequence, then flags and counts words that deviate from prediction.
module lfsr_checker #(
  parameter int LENGTH   = 16,
  parameter int TAPS     = 53256,
  parameter int TYPE     = 0,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LENGTH-1:0] data_in,
  input  logic              valid_in,
  input  logic              clear,
  output logic              locked,
  output logic              err_pulse,
  output logic              sync_loss,
  output logic              sticky_err,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  word_count
);

  localparam logic [LENGTH-1:0] TAP_MASK = LENGTH'(TAPS);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);
  localparam logic [MW-1:0] LOCK_V = MW'(LOCK_CNT);
  localparam logic [LW-1:0] LOSS_V = LW'(LOSS_CNT);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  function automatic logic [LENGTH-1:0] f_step(input logic [LENGTH-1:0] s);
    if (TYPE == 0) return {s[LENGTH-2:0], ^(s & TAP_MASK)};
    else           return {s[LENGTH-2:0], 1'b0} ^ (s[LENGTH-1] ? TAP_MASK : '0);
  endfunction

  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  state_t            r_state, w_state;
  logic [LENGTH-1:0] r_ref, w_ref;
  logic [MW-1:0]     r_match, w_match;
  logic [LW-1:0]     r_miss, w_miss;
  logic              r_err_pulse, w_err_pulse;
  logic              r_sync_loss, w_sync_loss;
  logic              r_sticky, w_sticky;
  logic [CNT_W-1:0]  r_err_cnt, w_err_cnt;
  logic [CNT_W-1:0]  r_word_cnt, w_word_cnt;
  logic [LENGTH-1:0] w_expect;
  logic              w_hit;
  logic [MW-1:0]     w_match_inc;
  logic [LW-1:0]     w_miss_inc;

  assign w_expect    = f_step(r_ref);
  assign w_hit       = (data_in == w_expect);
  assign w_match_inc = r_match + MW'(1);
  assign w_miss_inc  = r_miss + LW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= SEARCH;
      r_ref       <= '0;
      r_match     <= '0;
      r_miss      <= '0;
      r_err_pulse <= 1'b0;
      r_sync_loss <= 1'b0;
      r_sticky    <= 1'b0;
      r_err_cnt   <= '0;
      r_word_cnt  <= '0;
    end else begin
      r_state     <= w_state;
      r_ref       <= w_ref;
      r_match     <= w_match;
      r_miss      <= w_miss;
      r_err_pulse <= w_err_pulse;
      r_sync_loss <= w_sync_loss;
      r_sticky    <= w_sticky;
      r_err_cnt   <= w_err_cnt;
      r_word_cnt  <= w_word_cnt;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_ref       = r_ref;
    w_match     = r_match;
    w_miss      = r_miss;
    w_err_pulse = 1'b0;
    w_sync_loss = 1'b0;
    w_sticky    = r_sticky;
    w_err_cnt   = r_err_cnt;
    w_word_cnt  = r_word_cnt;
    if (valid_in) begin
      case (r_state)
        SEARCH: begin
          if (data_in != '0) begin
            w_ref   = data_in;
            w_match = '0;
            w_state = VERIFY;
          end
        end
        VERIFY: begin
          if (w_hit) begin
            w_ref   = data_in;
            w_match = w_match_inc;
            if (w_match_inc == LOCK_V) begin
              w_state = LOCKED;
              w_miss  = '0;
            end
          end else begin
            w_ref   = data_in;
            w_match = '0;
            if (data_in == '0) w_state = SEARCH;
          end
        end
        LOCKED: begin
          // Track the prediction, not the received word, so one bad word costs one error.
          w_ref      = w_expect;
          w_word_cnt = f_sat_inc(r_word_cnt);
          if (w_hit) begin
            w_miss = '0;
          end else begin
            w_err_pulse = 1'b1;
            w_sticky    = 1'b1;
            w_err_cnt   = f_sat_inc(r_err_cnt);
            if (w_miss_inc == LOSS_V) begin
              w_state     = SEARCH;
              w_sync_loss = 1'b1;
              w_miss      = '0;
            end else begin
              w_miss = w_miss_inc;
            end
          end
        end
        default: w_state = SEARCH;
      endcase
    end
    if (clear) begin
      w_err_cnt  = '0;
      w_word_cnt = '0;
      w_sticky   = 1'b0;
    end
  end

  assign locked     = (r_state == LOCKED);
  assign err_pulse  = r_err_pulse;
  assign sync_loss  = r_sync_loss;
  assign sticky_err = r_sticky;
  assign err_count  = r_err_cnt;
  assign word_count = r_word_cnt;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - directed bench for lfsr_checker in Fibonacci and Galois modes
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        rst, clear;
  logic [15:0] f_data, g_data;
  logic        f_valid, g_valid;
  logic        f_locked, f_err_pulse, f_sync_loss, f_sticky;
  logic [31:0] f_err_count, f_word_count;
  logic        g_locked, g_err_pulse, g_sync_loss, g_sticky;
  logic [31:0] g_err_count, g_word_count;
  logic [15:0] fs, ls, gs;
  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  lfsr_checker #(.LENGTH(16), .TAPS(53256), .TYPE(0), .LOCK_CNT(4), .LOSS_CNT(3), .CNT_W(32)) u_fib (
    .clk(clk), .rst(rst), .data_in(f_data), .valid_in(f_valid), .clear(clear),
    .locked(f_locked), .err_pulse(f_err_pulse), .sync_loss(f_sync_loss), .sticky_err(f_sticky),
    .err_count(f_err_count), .word_count(f_word_count)
  );

  lfsr_checker #(.LENGTH(16), .TAPS(53256), .TYPE(1), .LOCK_CNT(4), .LOSS_CNT(3), .CNT_W(32)) u_gal (
    .clk(clk), .rst(rst), .data_in(g_data), .valid_in(g_valid), .clear(1'b0),
    .locked(g_locked), .err_pulse(g_err_pulse), .sync_loss(g_sync_loss), .sticky_err(g_sticky),
    .err_count(g_err_count), .word_count(g_word_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] fib_step(input logic [15:0] s);
    return {s[14:0], ^(s & 16'hD008)};
  endfunction

  function automatic logic [15:0] gal_step(input logic [15:0] s);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'hD008 : 16'h0000);
  endfunction

  // One clock with the given inputs; returns 1 time unit after the sampling edge.
  task automatic fword(input logic [15:0] w, input logic v, input logic clr);
    @(negedge clk);
    f_data = w; f_valid = v; clear = clr;
    @(posedge clk);
    #1;
    f_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic gword(input logic [15:0] w, input logic v);
    @(negedge clk);
    g_data = w; g_valid = v;
    @(posedge clk);
    #1;
    g_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0;
    f_data = '0; f_valid = 1'b0; g_data = '0; g_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_locked", {31'd0, f_locked}, 32'd0);
    check("rst_err_pulse", {31'd0, f_err_pulse}, 32'd0);
    check("rst_sync_loss", {31'd0, f_sync_loss}, 32'd0);
    check("rst_sticky", {31'd0, f_sticky}, 32'd0);
    check("rst_err_count", f_err_count, 32'd0);
    check("rst_word_count", f_word_count, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < 6; k++) begin
      fword(16'h0000, 1'b1, 1'b0);
      check("zero_no_lock", {31'd0, f_locked}, 32'd0);
    end

    fs = 16'h0001;
    fword(fs, 1'b1, 1'b0);
    check("load_locked", {31'd0, f_locked}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      fs = fib_step(fs);
      fword(fs, 1'b1, 1'b0);
      check("verify_no_err", {31'd0, f_err_pulse}, 32'd0);
      check("lock_edge", {31'd0, f_locked}, (k == 4) ? 32'd1 : 32'd0);
    end
    check("lock_word_count", f_word_count, 32'd0);
    check("lock_err_count", f_err_count, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      fs = fib_step(fs);
      fword(fs, 1'b1, 1'b0);
      check("wc_step", f_word_count, 32'(k));
    end
    check("wc_err_count", f_err_count, 32'd0);

    for (int k = 0; k < 4; k++) begin
      int gaps;
      gaps = $urandom_range(1, 3);
      for (int j = 0; j < gaps; j++) begin
        fword(16'hBEEF, 1'b0, 1'b0);
        check("gap_err_pulse", {31'd0, f_err_pulse}, 32'd0);
        check("gap_word_count", f_word_count, 32'(3 + k));
      end
      fs = fib_step(fs);
      fword(fs, 1'b1, 1'b0);
    end
    check("gap_final_wc", f_word_count, 32'd7);
    check("gap_final_ec", f_err_count, 32'd0);
    check("gap_locked", {31'd0, f_locked}, 32'd1);

    fs = fib_step(fs);
    fword(fs ^ 16'h0100, 1'b1, 1'b0);
    check("corrupt_pulse", {31'd0, f_err_pulse}, 32'd1);
    check("corrupt_ec", f_err_count, 32'd1);
    check("corrupt_sticky", {31'd0, f_sticky}, 32'd1);
    check("corrupt_locked", {31'd0, f_locked}, 32'd1);
    check("corrupt_wc", f_word_count, 32'd8);
    fs = fib_step(fs);
    fword(fs, 1'b1, 1'b0);
    check("after_corrupt_pulse", {31'd0, f_err_pulse}, 32'd0);
    check("after_corrupt_ec", f_err_count, 32'd1);
    check("after_corrupt_wc", f_word_count, 32'd9);
    check("after_corrupt_locked", {31'd0, f_locked}, 32'd1);

    fs = fib_step(fs);
    fword(fs ^ 16'h0100, 1'b1, 1'b1);
    check("clear_ec", f_err_count, 32'd0);
    check("clear_wc", f_word_count, 32'd0);
    check("clear_sticky", {31'd0, f_sticky}, 32'd0);
    check("clear_locked", {31'd0, f_locked}, 32'd1);
    fs = fib_step(fs);
    fword(fs, 1'b1, 1'b0);
    check("post_clear_wc", f_word_count, 32'd1);
    check("post_clear_ec", f_err_count, 32'd0);

    ls = 16'hACE1;
    for (int k = 1; k <= 3; k++) begin
      fword(ls, 1'b1, 1'b0);
      check("loss_pulse", {31'd0, f_err_pulse}, 32'd1);
      check("loss_sync", {31'd0, f_sync_loss}, (k == 3) ? 32'd1 : 32'd0);
      check("loss_locked", {31'd0, f_locked}, (k == 3) ? 32'd0 : 32'd1);
      ls = fib_step(ls);
    end
    check("loss_ec", f_err_count, 32'd3);
    check("loss_wc", f_word_count, 32'd4);
    fword(ls, 1'b1, 1'b0);
    check("reload_sync", {31'd0, f_sync_loss}, 32'd0);
    check("reload_locked", {31'd0, f_locked}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      ls = fib_step(ls);
      fword(ls, 1'b1, 1'b0);
      check("relock", {31'd0, f_locked}, (k == 4) ? 32'd1 : 32'd0);
    end
    check("relock_ec", f_err_count, 32'd3);
    check("relock_sticky", {31'd0, f_sticky}, 32'd1);

    #3;
    rst = 1'b0;
    #1;
    check("async_locked", {31'd0, f_locked}, 32'd0);
    check("async_sticky", {31'd0, f_sticky}, 32'd0);
    check("async_ec", f_err_count, 32'd0);
    check("async_wc", f_word_count, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    ls = fib_step(ls);
    fword(ls, 1'b1, 1'b0);
    check("post_rst_unlocked", {31'd0, f_locked}, 32'd0);
    check("post_rst_err_pulse", {31'd0, f_err_pulse}, 32'd0);

    gword(16'h8000, 1'b1);
    gword(16'hD008, 1'b1);
    check("gal_not_yet", {31'd0, g_locked}, 32'd0);
    gs = 16'hD008;
    for (int k = 3; k <= 5; k++) begin
      gs = gal_step(gs);
      gword(gs, 1'b1);
      check("gal_lock", {31'd0, g_locked}, (k == 5) ? 32'd1 : 32'd0);
    end
    gs = gal_step(gs);
    gword(gs ^ 16'h0100, 1'b1);
    check("gal_corrupt_pulse", {31'd0, g_err_pulse}, 32'd1);
    check("gal_corrupt_ec", g_err_count, 32'd1);
    gs = gal_step(gs);
    gword(gs, 1'b1);
    check("gal_recover_pulse", {31'd0, g_err_pulse}, 32'd0);
    check("gal_recover_locked", {31'd0, g_locked}, 32'd1);
    check("gal_recover_wc", g_word_count, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
